// File: rtl/apb_timer8.sv
// apb_timer8: 8-bit APB timer with prescaler, up/down counting and OVF/UDF flags.
// Define TIMER_APB_WAIT_STATE_EN to insert one wait state in every APB access phase.
module apb_timer8 #(
    parameter logic [7:0] TDR_RST = 8'h00
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    apb_state_t state;

    logic [7:0] tdr;
    logic [7:0] tcnt;
    logic       load;
    logic       down;
    logic       en;
    logic [1:0] csel;
    logic       ovf;
    logic       udf;
    logic [3:0] psc;
    logic [3:0] psc_lim;
    logic       tick;
    logic       bad_access;
    logic       wr_ok;
    logic       tdr_wr;
    logic       tcr_wr;
    logic       tsr_wr;
    logic       ovf_set;
    logic       udf_set;

    // State records the bus phase sampled on the previous edge, so the first
    // access cycle is the one seen while in SETUP. A stray access without a
    // preceding setup (e.g. after reset mid-transfer) keeps the FSM in IDLE.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else if (psel && !penable) begin
            state <= SETUP;
        end else if (psel && penable && !pready && (state != IDLE)) begin
            state <= ACCESS;
        end else begin
            state <= IDLE;
        end
    end

`ifdef TIMER_APB_WAIT_STATE_EN
    assign pready = psel && penable && (state == ACCESS);
`else
    assign pready = psel && penable && (state == SETUP);
`endif

    assign bad_access = (paddr > 8'h03) || (pwrite && (paddr == 8'h03));
    assign pslverr    = pready && bad_access;
    assign wr_ok      = pready && pwrite && !bad_access;
    assign tdr_wr     = wr_ok && (paddr == 8'h00);
    assign tcr_wr     = wr_ok && (paddr == 8'h01);
    assign tsr_wr     = wr_ok && (paddr == 8'h02);

    always_comb begin
        prdata = 8'h00;
        if (pready && !bad_access) begin
            case (paddr[1:0])
                2'd0:    prdata = tdr;
                2'd1:    prdata = {load, 1'b0, down, en, 2'b00, csel};
                2'd2:    prdata = {6'b000000, udf, ovf};
                default: prdata = tcnt;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr  <= TDR_RST;
            load <= 1'b0;
            down <= 1'b0;
            en   <= 1'b0;
            csel <= 2'b00;
        end else begin
            if (tdr_wr) begin
                tdr <= pwdata;
            end
            if (tcr_wr) begin
                load <= pwdata[7];
                down <= pwdata[5];
                en   <= pwdata[4];
                csel <= pwdata[1:0];
            end
        end
    end

    always_comb begin
        case (csel)
            2'b00:   psc_lim = 4'd1;
            2'b01:   psc_lim = 4'd3;
            2'b10:   psc_lim = 4'd7;
            default: psc_lim = 4'd15;
        endcase
    end

    assign tick = en && (psc == psc_lim);

    // Changing the divisor restarts the prescaler so the first period is full length.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psc <= 4'd0;
        end else if (!en || tick || (tcr_wr && (pwdata[1:0] != csel))) begin
            psc <= 4'd0;
        end else begin
            psc <= psc + 4'd1;
        end
    end

    assign ovf_set = tick && !load && !down && (tcnt == 8'hFF);
    assign udf_set = tick && !load && down && (tcnt == 8'h00);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tcnt <= 8'h00;
        end else if (load) begin
            tcnt <= tdr;
        end else if (tick) begin
            tcnt <= down ? (tcnt - 8'd1) : (tcnt + 8'd1);
        end
    end

    // A flag set wins over a simultaneous write-one-to-clear.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_set || (ovf && !(tsr_wr && pwdata[0]));
            udf <= udf_set || (udf && !(tsr_wr && pwdata[1]));
        end
    end

endmodule

// File: tb/tb_apb_timer8.sv
// tb_apb_timer8: directed, table-driven self-checking bench for apb_timer8.
// Works with or without TIMER_APB_WAIT_STATE_EN defined.
module tb_apb_timer8;

`ifdef TIMER_APB_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif
    localparam logic [7:0] RST_VAL = 8'h3C;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int checks = 0;
    int fails = 0;

    apb_timer8 #(.TDR_RST(RST_VAL)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One APB transfer; gap adds idle cycles before the setup phase.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                                 input int gap, output logic [7:0] rdata, output logic err);
        int waits;
        repeat (gap) @(negedge pclk);
        @(negedge pclk);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = wdata;
        #1;
        checkOutput("pready_in_setup", {7'd0, pready}, 8'd0);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        waits = 0;
        while (!pready && waits < 4) begin
            @(negedge pclk);
            #1;
            waits++;
        end
        checkOutput("wait_states", waits[7:0], WS[7:0]);
        rdata = prdata;
        err = pslverr;
        @(negedge pclk);
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic doWrite(input logic [7:0] addr, input logic [7:0] data, input int gap);
        logic [7:0] rd;
        logic       er;
        applyStimulus(1'b1, addr, data, gap, rd, er);
        checkOutput($sformatf("wr_err_a%h", addr), {7'd0, er}, 8'd0);
    endtask

    task automatic doRead(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        logic       er;
        applyStimulus(1'b0, addr, 8'h00, 0, rd, er);
        checkOutput(name, rd, exp);
        checkOutput({name, "_err"}, {7'd0, er}, 8'd0);
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;

        vecs[0]  = '{1'b1, 8'h00, 8'h5A, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h5A, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0};
        vecs[4]  = '{1'b0, 8'h03, 8'h00, 8'h5A, 1'b0};
        vecs[5]  = '{1'b1, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 8'hC3, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 8'h03, 8'h00, 8'h5A, 1'b0};
        vecs[9]  = '{1'b0, 8'h07, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 8'h03, 8'h77, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 8'h03, 8'h00, 8'h5A, 1'b0};
        vecs[12] = '{1'b1, 8'h04, 8'h11, 8'h00, 1'b1};
        vecs[13] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[14] = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 8'h00, 8'hC3, 1'b0};
        vecs[16] = '{1'b1, 8'h01, 8'h4C, 8'h00, 1'b0};
        vecs[17] = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0};

        $display("[TB] Starting apb_timer8 bench, wait states = %0d", WS);
        repeat (3) @(negedge pclk);
        checkOutput("rst_pready", {7'd0, pready}, 8'd0);
        checkOutput("rst_pslverr", {7'd0, pslverr}, 8'd0);
        checkOutput("rst_prdata", prdata, 8'h00);
        presetn = 1'b1;

        doRead("rst_tdr", 8'h00, RST_VAL);
        doRead("rst_tcr", 8'h01, 8'h00);
        doRead("rst_tsr", 8'h02, 8'h00);
        doRead("rst_tcnt", 8'h03, 8'h00);

        // Up count /2 for a known span: ticks land on every second edge.
        doWrite(8'h01, 8'h10, 0);
        repeat (20) @(posedge pclk);
        doWrite(8'h01, 8'h00, 0);
        doRead("count_up_div2", 8'h03, 8'h0B);

        // Overflow with /4
        doWrite(8'h01, 8'h11, 0);
        repeat (1024) @(posedge pclk);
        doRead("ovf_tsr", 8'h02, 8'h01);
        doWrite(8'h01, 8'h00, 0);

        // Write-one-to-clear behaviour
        doWrite(8'h02, 8'h00, 0);
        doRead("tsr_w0_keeps", 8'h02, 8'h01);
        doWrite(8'h02, 8'h01, 0);
        doRead("tsr_w1_clears", 8'h02, 8'h00);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, rd, er);
            checkOutput($sformatf("vec%0d_err", i), {7'd0, er}, {7'd0, vecs[i].err});
            if (!vecs[i].wr)
                checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end

        // Down count from 5 with /2: underflow after six ticks
        doWrite(8'h00, 8'h05, 0);
        doWrite(8'h01, 8'h80, 0);
        doWrite(8'h01, 8'h30, 0);
        repeat (12) @(posedge pclk);
        doRead("udf_tsr", 8'h02, 8'h02);
        doRead("udf_tcnt", 8'h03, (WS == 1) ? 8'hFC : 8'hFD);
        doWrite(8'h01, 8'h00, 0);
        doWrite(8'h02, 8'h03, 0);
        doRead("udf_cleared", 8'h02, 8'h00);

        // Overflow edge coincides with a TSR clear of OVF
        doWrite(8'h00, 8'hFE, 0);
        doWrite(8'h01, 8'h80, 0);
        doWrite(8'h01, 8'h10, 0);
        doWrite(8'h02, 8'h01, (WS == 1) ? 0 : 1);
        doRead("set_beats_clear", 8'h02, 8'h01);
        doWrite(8'h01, 8'h00, 0);

        // Reset during the access phase of a TDR write
        doWrite(8'h00, 8'h99, 0);
        @(negedge pclk);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 8'h00;
        pwdata = 8'hAA;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        checkOutput("mid_pready_pre", {7'd0, pready}, (WS == 1) ? 8'd0 : 8'd1);
        #1;
        presetn = 1'b0;
        #1;
        checkOutput("mid_rst_pready", {7'd0, pready}, 8'd0);
        checkOutput("mid_rst_pslverr", {7'd0, pslverr}, 8'd0);
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        #1;
        checkOutput("post_rst_idle", {7'd0, pready}, 8'd0);
        @(negedge pclk);
        psel = 1'b0;
        penable = 1'b0;
        doRead("post_rst_tdr", 8'h00, RST_VAL);
        doRead("post_rst_tcr", 8'h01, 8'h00);
        doWrite(8'h00, 8'hAA, 0);
        doRead("post_rst_write", 8'h00, 8'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
